// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a
// saturating stall counter. Define ID_BRANCH_STALL_EN to also stall ID-stage branches.
module id_ex_hazard_stage #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic [3:0]       id_alu_op,
  input  logic             id_is_branch,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [4:0]       mem_rd,
  input  logic             mem_mem_read,
  input  logic             flush,
  output logic             ex_valid,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [3:0]       ex_alu_op,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ex_valid_q, ex_valid_d;
  logic [4:0]       ex_rs_q, ex_rs_d;
  logic [4:0]       ex_rt_q, ex_rt_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_reg_write_q, ex_reg_write_d;
  logic             ex_mem_read_q, ex_mem_read_d;
  logic             ex_mem_write_q, ex_mem_write_d;
  logic [3:0]       ex_alu_op_q, ex_alu_op_d;
  logic [DW-1:0]    ex_rs_data_q, ex_rs_data_d;
  logic [DW-1:0]    ex_rt_data_q, ex_rt_data_d;
  logic [DW-1:0]    ex_imm_q, ex_imm_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic branch_hazard;
  logic bubble;
  logic ctrl_en;

  always_comb begin
    load_use = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0) &
               ((ex_rd_q == id_rs) | (id_uses_rt & (ex_rd_q == id_rt)));
  end

`ifdef ID_BRANCH_STALL_EN
  // Branches resolve in ID, so any in-flight producer of a compared register must drain first.
  always_comb begin
    branch_hazard = id_valid & id_is_branch &
                    ((ex_valid_q & ex_reg_write_q & (ex_rd_q != 5'd0) &
                      ((ex_rd_q == id_rs) | (ex_rd_q == id_rt))) |
                     (mem_mem_read & (mem_rd != 5'd0) &
                      ((mem_rd == id_rs) | (mem_rd == id_rt))));
  end
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{id_is_branch, mem_rd, mem_mem_read};
  assign branch_hazard = 1'b0;
`endif

  // Stall is held low while in reset so the front end keeps running.
  always_comb begin
    stall      = rst_n & (load_use | branch_hazard) & ~flush;
    pc_write   = ~stall;
    ifid_write = ~stall;
  end

  always_comb begin
    bubble         = stall | flush;
    ctrl_en        = ~bubble & id_valid;
    ex_valid_d     = ctrl_en;
    ex_reg_write_d = ctrl_en & id_reg_write;
    ex_mem_read_d  = ctrl_en & id_mem_read;
    ex_mem_write_d = ctrl_en & id_mem_write;
    ex_alu_op_d    = ctrl_en ? id_alu_op : 4'd0;
    // Bubbles carry zero register indices so forwarding never matches them.
    ex_rs_d        = bubble ? 5'd0 : id_rs;
    ex_rt_d        = bubble ? 5'd0 : id_rt;
    ex_rd_d        = bubble ? 5'd0 : id_rd;
    ex_rs_data_d   = bubble ? '0 : id_rs_data;
    ex_rt_data_d   = bubble ? '0 : id_rt_data;
    ex_imm_d       = bubble ? '0 : id_imm;
    stall_cnt_d    = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_rs_q        <= 5'd0;
      ex_rt_q        <= 5'd0;
      ex_rd_q        <= 5'd0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_alu_op_q    <= 4'd0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      stall_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_alu_op_q    <= ex_alu_op_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign ex_alu_op    = ex_alu_op_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_imm       = ex_imm_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
